// File: rtl/gmux_pkg.sv
// ---------------------------------------------------------------------------
// gmux_pkg
// Shared definitions for the global-clock-mux select controller:
//   - FSM state encoding (gmux_state_t)
//   - settle/min-on counter width and episode counter width
//   - legal parameter ranges, plus small helpers used for the elaboration
//     range checks and for counter load values
// No ports; imported by gmux_sel_ctrl_if, gmux_req_sync and gmux_sel_ctrl.
// ---------------------------------------------------------------------------
package gmux_pkg;

  // Counter used for both the settle window and the minimum-on window
  localparam int CNT_W = 8;
  // Width of the completed-episode counter (wraps 255 -> 0)
  localparam int EP_W = 8;

  // Legal parameter ranges
  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 4;
  localparam int SETTLE_CYCLES_MIN = 1;
  localparam int SETTLE_CYCLES_MAX = 255;
  localparam int MIN_ON_CYCLES_MIN = 1;
  localparam int MIN_ON_CYCLES_MAX = 255;

  typedef logic [CNT_W-1:0] gmux_cnt_t;
  typedef logic [EP_W-1:0]  gmux_ep_t;

  // IDLE : mux deselected, no handshake
  // ARM  : request seen, clock held off while the mux input settles
  // ON   : clock passed downstream
  // DRAIN: clock removed, acknowledge still held while the mux settles
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } gmux_state_t;

  function automatic bit inRange(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

  // A window of N cycles is timed by loading N-1 and leaving on zero
  function automatic gmux_cnt_t cntLoad(input int cycles);
    return gmux_cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/gmux_sel_ctrl_if.sv
// ---------------------------------------------------------------------------
// gmux_sel_ctrl_if
// Bundles the request/kill inputs and the mux-select/handshake outputs of
// the global-clock-mux select controller.
//   req      : enable request, asynchronous level (four-phase handshake)
//   forceOff : synchronous kill, overrides req
//   is0      : select to the downstream clock mux, 1 passes the clock
//   ack      : handshake acknowledge, level
//   abort    : one-cycle pulse when a request is withdrawn while arming
//   episodes : count of completed ARM->ON transitions
// Modports: master (requester side), slave (controller side).
// ---------------------------------------------------------------------------
interface gmux_sel_ctrl_if;
  import gmux_pkg::*;

  logic     req;
  logic     forceOff;
  logic     is0;
  logic     ack;
  logic     abort;
  gmux_ep_t episodes;

  modport master (
    output req,
    output forceOff,
    input  is0,
    input  ack,
    input  abort,
    input  episodes
  );

  modport slave (
    input  req,
    input  forceOff,
    output is0,
    output ack,
    output abort,
    output episodes
  );

endinterface

// File: rtl/gmux_req_sync.sv
// ---------------------------------------------------------------------------
// gmux_req_sync
// Multi-flop synchroniser bringing the asynchronous request level into the
// control clock domain. Only the last stage is used downstream.
// Ports:
//   i_clk   : control clock
//   i_rst   : synchronous active-high reset, clears every stage to 0
//   i_async : asynchronous input level
//   o_sync  : synchronised level (last stage)
// ---------------------------------------------------------------------------
module gmux_req_sync
  import gmux_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_stages;

  // Shift register: the input enters stage 0 and moves one stage per edge.
  // Reset forces every stage low so a request present during reset is only
  // seen after the full synchroniser delay.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/gmux_sel_ctrl.sv
// ---------------------------------------------------------------------------
// gmux_sel_ctrl
// Select controller for a glitch-free global clock mux. A request is
// synchronised, then the mux input is given SETTLE_CYCLES to settle before
// the select (is0) is raised. Once on, the select stays high for at least
// MIN_ON_CYCLES. On release (or kill) the select drops at once, while the
// acknowledge is held for a further SETTLE_CYCLES so the requester cannot
// re-request before the mux has settled.
// Parameters:
//   SYNC_STAGES   : request synchroniser depth (2..4)
//   SETTLE_CYCLES : cycles the select is held low before assertion and
//                   after deassertion (1..255)
//   MIN_ON_CYCLES : minimum cycles the select stays high (1..255)
// Ports:
//   i_qck   : control clock
//   i_qrt   : synchronous active-high reset
//   io_gmux : request/kill inputs and select/handshake outputs
// ---------------------------------------------------------------------------
module gmux_sel_ctrl
  import gmux_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int MIN_ON_CYCLES = 8
) (
  input  logic            i_qck,
  input  logic            i_qrt,
  gmux_sel_ctrl_if.slave  io_gmux
);

  // Out-of-range parameters stop elaboration
  if (!inRange(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX)) begin : g_badSync
    $error("gmux_sel_ctrl: SYNC_STAGES=%0d out of range", SYNC_STAGES);
  end
  if (!inRange(SETTLE_CYCLES, SETTLE_CYCLES_MIN, SETTLE_CYCLES_MAX)) begin : g_badSettle
    $error("gmux_sel_ctrl: SETTLE_CYCLES=%0d out of range", SETTLE_CYCLES);
  end
  if (!inRange(MIN_ON_CYCLES, MIN_ON_CYCLES_MIN, MIN_ON_CYCLES_MAX)) begin : g_badMinOn
    $error("gmux_sel_ctrl: MIN_ON_CYCLES=%0d out of range", MIN_ON_CYCLES);
  end

  localparam gmux_cnt_t SETTLE_LOAD = cntLoad(SETTLE_CYCLES);
  localparam gmux_cnt_t MIN_ON_LOAD = cntLoad(MIN_ON_CYCLES);
  localparam gmux_cnt_t CNT_ONE     = gmux_cnt_t'(1);
  localparam gmux_ep_t  EP_ONE      = gmux_ep_t'(1);

  gmux_state_t r_state;
  gmux_cnt_t   r_cnt;
  logic        r_is0;
  logic        r_ack;
  logic        r_abort;
  gmux_ep_t    r_episodes;

  gmux_state_t w_nextState;
  gmux_cnt_t   w_nextCnt;
  logic        w_nextAbort;
  gmux_ep_t    w_nextEpisodes;
  logic        w_nextIs0;
  logic        w_nextAck;
  logic        w_reqS;
  logic        w_forceOff;

  assign w_forceOff = io_gmux.forceOff;

  gmux_req_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reqSync (
    .i_clk   (i_qck),
    .i_rst   (i_qrt),
    .i_async (io_gmux.req),
    .o_sync  (w_reqS)
  );

  // Next-state logic. The single counter times whichever window the current
  // state needs: settle in ARM/DRAIN, minimum-on in ON (saturating at zero
  // so a long-held request simply keeps the select high). forceOff is
  // checked first so it always beats a simultaneous request.
  always_comb begin
    w_nextState    = r_state;
    w_nextCnt      = r_cnt;
    w_nextAbort    = 1'b0;
    w_nextEpisodes = r_episodes;

    case (r_state)
      IDLE: begin
        if (w_reqS && !w_forceOff) begin
          w_nextState = ARM;
          w_nextCnt   = SETTLE_LOAD;
        end
      end

      ARM: begin
        if (w_forceOff) begin
          w_nextState = DRAIN;
          w_nextCnt   = SETTLE_LOAD;
        end else if (!w_reqS) begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
          w_nextAbort = 1'b1;
        end else if (r_cnt == '0) begin
          w_nextState    = ON;
          w_nextCnt      = MIN_ON_LOAD;
          w_nextEpisodes = r_episodes + EP_ONE;
        end else begin
          w_nextCnt = r_cnt - CNT_ONE;
        end
      end

      ON: begin
        if (w_forceOff || (!w_reqS && (r_cnt == '0))) begin
          w_nextState = DRAIN;
          w_nextCnt   = SETTLE_LOAD;
        end else if (r_cnt != '0) begin
          w_nextCnt = r_cnt - CNT_ONE;
        end
      end

      DRAIN: begin
        if (r_cnt == '0) begin
          w_nextState = IDLE;
        end else begin
          w_nextCnt = r_cnt - CNT_ONE;
        end
      end

      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // The outputs are decoded from the next state and registered, so is0 and
  // ack come straight from flops and can only change at a clock edge.
  always_comb begin
    w_nextIs0 = (w_nextState == ON);
    w_nextAck = (w_nextState == ON) || (w_nextState == DRAIN);
  end

  // State, counter and output registers. Reset drops the select on the
  // reset edge itself, with no drain window, abort pulse or episode count.
  always_ff @(posedge i_qck) begin
    if (i_qrt) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is0      <= 1'b0;
      r_ack      <= 1'b0;
      r_abort    <= 1'b0;
      r_episodes <= '0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      r_is0      <= w_nextIs0;
      r_ack      <= w_nextAck;
      r_abort    <= w_nextAbort;
      r_episodes <= w_nextEpisodes;
    end
  end

  assign io_gmux.is0      = r_is0;
  assign io_gmux.ack      = r_ack;
  assign io_gmux.abort    = r_abort;
  assign io_gmux.episodes = r_episodes;

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gmux_sel_ctrl
// Self-checking bench for gmux_sel_ctrl with default parameters. A timing
// model (request delay queue plus elapsed-cycle phase timing) predicts every
// output each cycle; directed scenarios add literal expectations at the
// edge numbers worked out by hand from the request timing.
// ---------------------------------------------------------------------------
module tb_gmux_sel_ctrl;

  localparam int SYNC   = 2;
  localparam int SETTLE = 4;
  localparam int MINON  = 8;

  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_ON    = 2;
  localparam int P_DRAIN = 3;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   relEdge = 0;

  gmux_sel_ctrl_if bus ();

  gmux_sel_ctrl #(
    .SYNC_STAGES   (SYNC),
    .SETTLE_CYCLES (SETTLE),
    .MIN_ON_CYCLES (MINON)
  ) dut (
    .i_qck   (clock),
    .i_qrt   (reset),
    .io_gmux (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge numbering: edge 1 is the first rising edge with reset low
  always @(posedge clock) begin
    if (reset) relEdge <= 0;
    else       relEdge <= relEdge + 1;
  end

  // Timing model: the request is seen SYNC edges late, and each phase is
  // timed by how many edges have elapsed since it was entered.
  int mPhase = P_IDLE;
  int mAge = 0;
  int mEp = 0;
  bit mAbort = 1'b0;
  bit reqPipe[$] = '{1'b0, 1'b0};

  always @(posedge clock) begin
    bit seen;
    seen = reqPipe[$];
    reqPipe.push_front(bus.req);
    void'(reqPipe.pop_back());
    mAbort = 1'b0;
    if (reset) begin
      mPhase = P_IDLE;
      mAge = 0;
      mEp = 0;
      reqPipe = '{1'b0, 1'b0};
    end else begin
      case (mPhase)
        P_IDLE: if (seen && !bus.forceOff) begin mPhase = P_ARM; mAge = 0; end
        P_ARM: begin
          if (bus.forceOff) begin mPhase = P_DRAIN; mAge = 0; end
          else if (!seen) begin mPhase = P_IDLE; mAbort = 1'b1; end
          else if (mAge == SETTLE - 1) begin mPhase = P_ON; mAge = 0; mEp = (mEp + 1) % 256; end
          else mAge++;
        end
        P_ON: begin
          if (bus.forceOff || (!seen && mAge >= MINON - 1)) begin mPhase = P_DRAIN; mAge = 0; end
          else mAge++;
        end
        default: begin
          if (mAge == SETTLE - 1) mPhase = P_IDLE;
          else mAge++;
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", name, relEdge, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    checkOutput("model_is0", int'(bus.is0), int'(mPhase == P_ON));
    checkOutput("model_ack", int'(bus.ack), int'(mPhase == P_ON || mPhase == P_DRAIN));
    checkOutput("model_abort", int'(bus.abort), int'(mAbort));
    checkOutput("model_episodes", int'(bus.episodes), mEp);
  end

  task automatic applyStimulus(input logic reqV, input logic forceV);
    bus.req = reqV;
    bus.forceOff = forceV;
  endtask

  task automatic stepTo(input int k);
    while (relEdge < k) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Two reset edges, check the reset state, then release reset so the next
  // rising edge is edge 1
  task automatic resetDut(input logic reqV, input logic forceV);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1;
    checkOutput("reset_is0", int'(bus.is0), 0);
    checkOutput("reset_ack", int'(bus.ack), 0);
    checkOutput("reset_abort", int'(bus.abort), 0);
    checkOutput("reset_episodes", int'(bus.episodes), 0);
    reset = 1'b0;
    applyStimulus(reqV, forceV);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);

    // Request, min-on release, drain
    resetDut(1'b1, 1'b0);
    stepTo(6);
    checkOutput("arm_is0_e6", int'(bus.is0), 0);
    stepTo(7);
    checkOutput("on_is0_e7", int'(bus.is0), 1);
    checkOutput("on_ack_e7", int'(bus.ack), 1);
    checkOutput("on_ep_e7", int'(bus.episodes), 1);
    stepTo(8);
    applyStimulus(1'b0, 1'b0);
    stepTo(14);
    checkOutput("minon_is0_e14", int'(bus.is0), 1);
    stepTo(15);
    checkOutput("drain_is0_e15", int'(bus.is0), 0);
    checkOutput("drain_ack_e15", int'(bus.ack), 1);
    stepTo(18);
    checkOutput("drain_ack_e18", int'(bus.ack), 1);
    stepTo(19);
    checkOutput("idle_ack_e19", int'(bus.ack), 0);

    // Short request withdrawn during ARM
    resetDut(1'b1, 1'b0);
    stepTo(1);
    applyStimulus(1'b0, 1'b0);
    stepTo(3);
    checkOutput("abort_e3", int'(bus.abort), 0);
    stepTo(4);
    checkOutput("abort_e4", int'(bus.abort), 1);
    stepTo(5);
    checkOutput("abort_e5", int'(bus.abort), 0);
    stepTo(12);
    checkOutput("abort_is0_e12", int'(bus.is0), 0);
    checkOutput("abort_ep_e12", int'(bus.episodes), 0);

    // Kill while ON, request still high re-arms after the drain
    resetDut(1'b1, 1'b0);
    stepTo(8);
    applyStimulus(1'b1, 1'b1);
    stepTo(9);
    applyStimulus(1'b1, 1'b0);
    checkOutput("kill_is0_e9", int'(bus.is0), 0);
    checkOutput("kill_ack_e9", int'(bus.ack), 1);
    checkOutput("kill_abort_e9", int'(bus.abort), 0);
    stepTo(13);
    checkOutput("kill_ack_e13", int'(bus.ack), 0);
    stepTo(17);
    checkOutput("rearm_is0_e17", int'(bus.is0), 0);
    stepTo(18);
    checkOutput("rearm_is0_e18", int'(bus.is0), 1);
    checkOutput("rearm_ep_e18", int'(bus.episodes), 2);

    // Kill together with request holds IDLE
    resetDut(1'b1, 1'b1);
    stepTo(10);
    checkOutput("hold_is0_e10", int'(bus.is0), 0);
    checkOutput("hold_ack_e10", int'(bus.ack), 0);
    applyStimulus(1'b1, 1'b0);
    stepTo(14);
    checkOutput("hold_is0_e14", int'(bus.is0), 0);
    stepTo(15);
    checkOutput("hold_is0_e15", int'(bus.is0), 1);

    // Kill during ARM, kill held through DRAIN has no effect
    resetDut(1'b1, 1'b0);
    stepTo(4);
    applyStimulus(1'b1, 1'b1);
    stepTo(5);
    checkOutput("armkill_ack_e5", int'(bus.ack), 1);
    checkOutput("armkill_abort_e5", int'(bus.abort), 0);
    stepTo(8);
    checkOutput("armkill_ack_e8", int'(bus.ack), 1);
    stepTo(9);
    checkOutput("armkill_ack_e9", int'(bus.ack), 0);
    stepTo(12);
    checkOutput("armkill_is0_e12", int'(bus.is0), 0);
    applyStimulus(1'b1, 1'b0);
    stepTo(17);
    checkOutput("armkill_is0_e17", int'(bus.is0), 1);
    checkOutput("armkill_ep_e17", int'(bus.episodes), 1);

    // 256 episodes wrap the counter, then reset while ON
    resetDut(1'b1, 1'b0);
    for (int n = 0; n < 255; n++) begin
      stepTo(8 + 11 * n);
      if (n == 254) begin
        checkOutput("wrap_ep_255", int'(bus.episodes), 255);
        checkOutput("wrap_is0_255", int'(bus.is0), 1);
      end
      applyStimulus(1'b1, 1'b1);
      stepTo(9 + 11 * n);
      applyStimulus(1'b1, 1'b0);
    end
    stepTo(2812);
    checkOutput("wrap_ep_0", int'(bus.episodes), 0);
    checkOutput("wrap_is0_on", int'(bus.is0), 1);
    stepTo(2813);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rston_is0", int'(bus.is0), 0);
    checkOutput("rston_ack", int'(bus.ack), 0);
    checkOutput("rston_abort", int'(bus.abort), 0);
    checkOutput("rston_ep", int'(bus.episodes), 0);
    reset = 1'b0;
    stepTo(6);
    checkOutput("postrst_is0_e6", int'(bus.is0), 0);
    stepTo(7);
    checkOutput("postrst_is0_e7", int'(bus.is0), 1);
    checkOutput("postrst_ep_e7", int'(bus.episodes), 1);
    stepTo(9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
